// File: rtl/alu_stage_pkg.sv
// Shared constants for the ALU operand stage: widths, opcodes, operand-source selects, status bit positions.
package alu_stage_pkg;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_SUBR = 2'b00,
    OP_OR   = 2'b01,
    OP_ADD  = 2'b10,
    OP_XNOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_AB = 2'b00,
    SRC_AQ = 2'b01,
    SRC_DA = 2'b10,
    SRC_ZB = 2'b11
  } src_sel_e;

  localparam int ST_C = 3;
  localparam int ST_V = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

  function automatic logic is_logical(logic [1:0] op);
    return (op == OP_OR) || (op == OP_XNOR);
  endfunction
endpackage

// File: rtl/alu_operand_stage_if.sv
// Instruction handshake plus the operand/result bus between the operand stage and the ALU.
interface alu_operand_stage_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              in_valid, in_ready, hold;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [1:0]        src_sel, op_in;
  logic [DATA_W-1:0] d_in;
  logic              ci_in, ci_sel, wb_en, q_en;
  logic [DATA_W-1:0] alu_r, alu_s, alu_f;
  logic              alu_ci, alu_valid;
  logic [1:0]        alu_i;
  logic              alu_co, alu_vo, alu_no, alu_zo;

  modport slave (
    input  in_valid, hold, a_addr, b_addr, src_sel, op_in, d_in, ci_in, ci_sel, wb_en, q_en,
    input  alu_f, alu_co, alu_vo, alu_no, alu_zo,
    output in_ready, alu_r, alu_s, alu_ci, alu_i, alu_valid
  );

  modport master (
    output in_valid, hold, a_addr, b_addr, src_sel, op_in, d_in, ci_in, ci_sel, wb_en, q_en,
    output alu_f, alu_co, alu_vo, alu_no, alu_zo,
    input  in_ready, alu_r, alu_s, alu_ci, alu_i, alu_valid
  );
endinterface

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, cleared by async reset.
module alu_regfile
  import alu_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);
  logic [2**ADDR_W-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  mem     <= '0;
    else if (we) mem[wa] <= wd;
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
endmodule

// File: rtl/alu_operand_stage.sv
// Operand select/register stage feeding a combinational 4-bit ALU, with result/flag commit.
// Build option REGFILE_BYPASS_EN: forward in-flight results instead of stalling on hazards.
module alu_operand_stage
  import alu_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_operand_stage_if.slave   bus,
  output logic [3:0]           status
);
  logic [DATA_W-1:0] rd_a, rd_b, q_r, a_val, b_val, q_val, r_nxt, s_nxt;
  logic [ADDR_W-1:0] dst_l;
  logic              wb_l, q_l, c_val, ci_nxt, accept, commit, hazard;
  logic [3:0]        st_r, st_cm;

  assign commit = bus.alu_valid;

  alu_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra_addr(bus.a_addr), .ra_data(rd_a),
    .rb_addr(bus.b_addr), .rb_data(rd_b),
    .we(commit && wb_l), .wa(dst_l), .wd(bus.alu_f)
  );

  // Logical ops never produce a meaningful carry/overflow, so they commit as zero.
  always_comb begin
    st_cm       = '0;
    st_cm[ST_C] = bus.alu_co && !is_logical(bus.alu_i);
    st_cm[ST_V] = bus.alu_vo && !is_logical(bus.alu_i);
    st_cm[ST_N] = bus.alu_no;
    st_cm[ST_Z] = bus.alu_zo;
  end

`ifdef REGFILE_BYPASS_EN
  assign a_val  = (commit && wb_l && bus.a_addr == dst_l) ? bus.alu_f : rd_a;
  assign b_val  = (commit && wb_l && bus.b_addr == dst_l) ? bus.alu_f : rd_b;
  assign q_val  = (commit && q_l) ? bus.alu_f : q_r;
  assign c_val  = commit ? st_cm[ST_C] : st_r[ST_C];
  assign hazard = 1'b0;
`else
  logic rd_a_use, rd_b_use, rd_q_use;
  assign rd_a_use = bus.src_sel != SRC_ZB;
  assign rd_b_use = (bus.src_sel == SRC_AB) || (bus.src_sel == SRC_ZB);
  assign rd_q_use = bus.src_sel == SRC_AQ;
  assign a_val    = rd_a;
  assign b_val    = rd_b;
  assign q_val    = q_r;
  assign c_val    = st_r[ST_C];
  // Every in-flight op rewrites status, so a carry-chained op always waits.
  assign hazard   = commit && ((wb_l && rd_a_use && bus.a_addr == dst_l) ||
                               (wb_l && rd_b_use && bus.b_addr == dst_l) ||
                               (q_l && rd_q_use) || bus.ci_sel);
`endif

  assign bus.in_ready = rst_n && !bus.hold && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    r_nxt = a_val;
    s_nxt = b_val;
    case (bus.src_sel)
      SRC_AB:  begin r_nxt = a_val;     s_nxt = b_val; end
      SRC_AQ:  begin r_nxt = a_val;     s_nxt = q_val; end
      SRC_DA:  begin r_nxt = bus.d_in;  s_nxt = a_val; end
      default: begin r_nxt = '0;        s_nxt = b_val; end
    endcase
  end

  assign ci_nxt = bus.ci_sel ? c_val : bus.ci_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_r     <= '0;
      bus.alu_s     <= '0;
      bus.alu_ci    <= 1'b0;
      bus.alu_i     <= '0;
      bus.alu_valid <= 1'b0;
      dst_l         <= '0;
      wb_l          <= 1'b0;
      q_l           <= 1'b0;
      q_r           <= '0;
      st_r          <= '0;
    end else begin
      bus.alu_valid <= accept;
      if (accept) begin
        bus.alu_r  <= r_nxt;
        bus.alu_s  <= s_nxt;
        bus.alu_ci <= ci_nxt;
        bus.alu_i  <= bus.op_in;
        dst_l      <= bus.b_addr;
        wb_l       <= bus.wb_en;
        q_l        <= bus.q_en;
      end
      if (commit) begin
        if (q_l) q_r <= bus.alu_f;
        st_r <= st_cm;
      end
    end
  end

  assign status = st_r;
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Upstream feeder for the 4-bit ALU (ops: S-R-1+CI, S|R, S+R+CI, ~(S^R)).
- Holds a 16-entry register file, a Q register and a registered status word (C,V,N,Z).
- Selects and registers the R/S operands, CI and opcode each accepted instruction; the combinational ALU evaluates them the following cycle.
- Commits the ALU result and flags back at the end of that cycle; one instruction per clock.

Parameters:
- DATA_W, 4, datapath width; must match ALU width.
- ADDR_W, 4, register-file address width (2**ADDR_W entries).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- hold  in  1  blocks acceptance; in-flight op still commits.
- a_addr  in  ADDR_W  read port A.
- b_addr  in  ADDR_W  read port B; also write-back destination.
- src_sel  in  2  00 R=A,S=B; 01 R=A,S=Q; 10 R=D,S=A; 11 R=0,S=B.
- d_in  in  DATA_W  direct operand.
- ci_in  in  1  external carry-in.
- ci_sel  in  1  0 CI=ci_in; 1 CI=status C (multiword chaining).
- op_in  in  2  ALU opcode, passed to ALU I.
- wb_en  in  1  write F to reg[b_addr] at commit.
- q_en  in  1  write F to Q at commit.
- alu_r, alu_s  out  DATA_W  registered operands to ALU.
- alu_ci  out  1  registered carry-in.
- alu_i  out  2  registered opcode.
- alu_valid  out  1  operands valid this cycle.
- alu_f  in  DATA_W  ALU result (combinational from alu_* outputs).
- alu_co, alu_vo, alu_no, alu_zo  in  1  ALU flags.
- status  out  4  {C,V,N,Z}, last committed flags.

Behaviour:
- Reset (async, rst_n=0): all regs, Q, status, alu_r/s/ci/i = 0; alu_valid=0; pending wb/q enables cleared. in_ready=0 during reset.
- in_ready = !hold (bypass build). Accept at edge when in_valid && in_ready: latch operands per src_sel, CI per ci_sel, op_in, b_addr, wb_en, q_en; alu_valid<=1. No accept: alu_valid<=0.
- Commit: at each edge where alu_valid=1, reg[b_latched]<=alu_f if wb_en; Q<=alu_f if q_en; status<={alu_co,alu_vo,alu_no,alu_zo}. Logical ops: status C/V = 0.
- Latency: accept edge N -> alu_* valid cycle N+1 -> commit edge N+1. Throughput 1/clk.
- Forwarding: when accepting while alu_valid=1, reads of reg[b_latched] (wb_en), reads of Q (q_en), and status C (ci_sel=1) take alu_f / alu_co, not the stale stored value.
- Simultaneous accept and commit to the same register: read uses the forwarded value, write completes; both correct.
- hold=1 with op in flight: op commits; alu_valid falls next edge; operand outputs keep last values.
- wb_en=0 and q_en=0: flags still update (compare-only op).
- Reset mid-operation: in-flight commit discarded; no partial write.

Optional Feature:
- REGFILE_BYPASS_EN defined: forwarding as above; in_ready = !hold.
- Undefined: no forwarding paths; in_ready = !hold && !hazard, where hazard = alu_valid and the incoming op reads a location the in-flight op writes (reg, Q, or C via ci_sel=1). One-cycle bubble; results identical to bypass build.

Decomposition:
- Package alu_stage_pkg: DATA_W/ADDR_W defaults; opcode constants OP_SUBR=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_XNOR=2'b11; src_sel constants SRC_AB, SRC_AQ, SRC_DA, SRC_ZB; status bit indices.
- Sub-module alu_regfile: 2 async read ports, 1 sync write port, async-reset clear. Operand mux, forwarding and status live in the top module.

Test Plan:
- Reset, then SRC_DA, OP_ADD, d_in=5, a_addr=0, ci_in=0, wb_en, b_addr=1 -> alu_r=5, alu_s=0 next cycle; reg1=5; status Z=0.
- Back-to-back: SRC_AB, OP_ADD, a=1, b=1, wb_en -> forwarded 5+5, F=0xA, status C=0 V=1 N=1 Z=0. Non-bypass build: one cycle in_ready=0, same result.
- Chain: reg2=0xF, reg3=0x1; ADD a=2, b=3 -> F=0, C=1 Z=1; next ADD ci_sel=1 of 0+0 -> F=1 (forwarded carry).
- OP_SUBR S=7, R=3, ci_in=1 -> F=4; OP_XNOR S=0xA, R=0xA -> F=0xF, N=1, C=V=0.
- hold=1 on the cycle after accept -> in_ready=0, in-flight write lands, alu_valid=0 next cycle, no new commit.
- rst_n pulsed low mid-op with wb_en to reg5 -> reg5 stays 0, status=0, alu_valid=0 immediately.
